fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin byte writer merging register-file reads and ALU results into a FIFO
// RF bytes and 16-bit ALU results are held in single-entry buffers and drained one byte per cycle.
module fifo_wr_arbiter #(
  parameter logic LSB_FIRST = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [7:0]  Rd_DATA,
  input  logic        Rd_Valid,
  input  logic [15:0] ALU_OUT,
  input  logic        OUT_VALID,
  input  logic        FIFO_FULL,
  input  logic        CLR_ERR,
  output logic        WR_INC,
  output logic [7:0]  WR_DATA,
  output logic        RF_PEND,
  output logic        ALU_PEND,
  output logic        BUSY,
  output logic        OVF
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] SEND_RF     = 2'd1;
  localparam logic [1:0] SEND_ALU_B0 = 2'd2;
  localparam logic [1:0] SEND_ALU_B1 = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        last_alu_q, last_alu_d;
  logic        rf_pend_q, rf_pend_d;
  logic        alu_pend_q, alu_pend_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  rf_buf_q, rf_buf_d;
  logic [15:0] alu_buf_q, alu_buf_d;

  logic        wr_inc;
  logic        rf_free, alu_free;
  logic        rf_drop, alu_drop;
  logic [7:0]  alu_first_byte, alu_second_byte;

  assign wr_inc   = RST_n & ~FIFO_FULL & (state_q != IDLE);
  assign rf_free  = wr_inc & (state_q == SEND_RF);
  assign alu_free = wr_inc & (state_q == SEND_ALU_B1);

  // A strobe landing on the freeing cycle refills the buffer instead of overflowing.
  assign rf_drop  = Rd_Valid  & rf_pend_q  & ~rf_free;
  assign alu_drop = OUT_VALID & alu_pend_q & ~alu_free;

  assign alu_first_byte  = LSB_FIRST ? alu_buf_q[7:0]  : alu_buf_q[15:8];
  assign alu_second_byte = LSB_FIRST ? alu_buf_q[15:8] : alu_buf_q[7:0];

  always_comb begin
    state_d    = state_q;
    last_alu_d = last_alu_q;
    case (state_q)
      IDLE: begin
        // The tie-break pointer only moves when both sources compete.
        if (rf_pend_q && alu_pend_q) begin
          if (last_alu_q) begin
            state_d    = SEND_RF;
            last_alu_d = 1'b0;
          end else begin
            state_d    = SEND_ALU_B0;
            last_alu_d = 1'b1;
          end
        end else if (rf_pend_q) begin
          state_d = SEND_RF;
        end else if (alu_pend_q) begin
          state_d = SEND_ALU_B0;
        end
      end
      SEND_RF:     if (wr_inc) state_d = IDLE;
      SEND_ALU_B0: if (wr_inc) state_d = SEND_ALU_B1;
      SEND_ALU_B1: if (wr_inc) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_pend_d  = rf_pend_q;
    rf_buf_d   = rf_buf_q;
    alu_pend_d = alu_pend_q;
    alu_buf_d  = alu_buf_q;
    ovf_d      = ovf_q;

    if (Rd_Valid && !rf_drop) begin
      rf_pend_d = 1'b1;
      rf_buf_d  = Rd_DATA;
    end else if (rf_free) begin
      rf_pend_d = 1'b0;
    end

    if (OUT_VALID && !alu_drop) begin
      alu_pend_d = 1'b1;
      alu_buf_d  = ALU_OUT;
    end else if (alu_free) begin
      alu_pend_d = 1'b0;
    end

    if (rf_drop || alu_drop) begin
      ovf_d = 1'b1;
    end else if (CLR_ERR) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q    <= IDLE;
      last_alu_q <= 1'b1;
      rf_pend_q  <= 1'b0;
      alu_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      rf_buf_q   <= 8'h00;
      alu_buf_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      last_alu_q <= last_alu_d;
      rf_pend_q  <= rf_pend_d;
      alu_pend_q <= alu_pend_d;
      ovf_q      <= ovf_d;
      rf_buf_q   <= rf_buf_d;
      alu_buf_q  <= alu_buf_d;
    end
  end

  always_comb begin
    WR_DATA = 8'h00;
    case (state_q)
      SEND_RF:     WR_DATA = rf_buf_q;
      SEND_ALU_B0: WR_DATA = alu_first_byte;
      SEND_ALU_B1: WR_DATA = alu_second_byte;
      default:     WR_DATA = 8'h00;
    endcase
  end

  assign WR_INC   = wr_inc;
  assign RF_PEND  = rf_pend_q;
  assign ALU_PEND = alu_pend_q;
  assign BUSY     = (state_q != IDLE);
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and random checks of fifo_wr_arbiter against a byte-queue model
// Two instances (LSB-first and MSB-first) share stimulus and are compared every cycle.
module tb_fifo_wr_arbiter;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic [7:0]  Rd_DATA = 8'h00;
  logic        Rd_Valid = 1'b0;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        OUT_VALID = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        CLR_ERR = 1'b0;

  logic        inc_l, inc_m, rfp_l, rfp_m, alp_l, alp_m, busy_l, busy_m, ovf_l, ovf_m;
  logic [7:0]  dat_l, dat_m;

  always #5 CLK = ~CLK;

  fifo_wr_arbiter #(.LSB_FIRST(1'b1)) u_dut_lsb (
    .CLK(CLK), .RST_n(RST_n), .Rd_DATA(Rd_DATA), .Rd_Valid(Rd_Valid),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .FIFO_FULL(FIFO_FULL), .CLR_ERR(CLR_ERR),
    .WR_INC(inc_l), .WR_DATA(dat_l), .RF_PEND(rfp_l), .ALU_PEND(alp_l),
    .BUSY(busy_l), .OVF(ovf_l)
  );

  fifo_wr_arbiter #(.LSB_FIRST(1'b0)) u_dut_msb (
    .CLK(CLK), .RST_n(RST_n), .Rd_DATA(Rd_DATA), .Rd_Valid(Rd_Valid),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .FIFO_FULL(FIFO_FULL), .CLR_ERR(CLR_ERR),
    .WR_INC(inc_m), .WR_DATA(dat_m), .RF_PEND(rfp_m), .ALU_PEND(alp_m),
    .BUSY(busy_m), .OVF(ovf_m)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cnt77   = 0;

  // Reference model: pending buffers plus the queue of bytes still owed to the FIFO.
  logic [7:0]  q_l[$];
  logic [7:0]  q_m[$];
  logic        m_valid = 1'b0;
  logic        m_rf_pend, m_alu_pend, m_ovf, m_last_alu, m_src_alu;
  logic [7:0]  m_rf_buf;
  logic [15:0] m_alu_buf;

  logic        obs_inc_l, obs_inc_m, obs_rfp, obs_alp, obs_busy, obs_ovf;
  logic [7:0]  obs_dat_l, obs_dat_m;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rv, input logic [7:0] rd,
                      input logic ov, input logic [15:0] alu,
                      input logic full, input logic clr);
    logic       e_inc, e_busy, pop, last_byte, free_rf, free_alu, was_idle;
    logic       g_rf, g_alu, ovf_new;
    logic [7:0] e_dl, e_dm;
    @(negedge CLK);
    RST_n = rst; Rd_Valid = rv; Rd_DATA = rd; OUT_VALID = ov; ALU_OUT = alu;
    FIFO_FULL = full; CLR_ERR = clr;
    #1;
    obs_inc_l = inc_l; obs_inc_m = inc_m; obs_dat_l = dat_l; obs_dat_m = dat_m;
    obs_rfp = rfp_l; obs_alp = alp_l; obs_busy = busy_l; obs_ovf = ovf_l;
    if (inc_l && dat_l == 8'h77) cnt77++;

    e_busy = (q_l.size() != 0);
    e_inc  = rst && !full && e_busy;
    e_dl   = e_busy ? q_l[0] : 8'h00;
    e_dm   = e_busy ? q_m[0] : 8'h00;
    if (m_valid) begin
      chk("wr_inc_lsb", inc_l, e_inc);     chk("wr_inc_msb", inc_m, e_inc);
      chk("wr_data_lsb", dat_l, e_dl);     chk("wr_data_msb", dat_m, e_dm);
      chk("rf_pend_lsb", rfp_l, m_rf_pend); chk("rf_pend_msb", rfp_m, m_rf_pend);
      chk("alu_pend_lsb", alp_l, m_alu_pend); chk("alu_pend_msb", alp_m, m_alu_pend);
      chk("busy_lsb", busy_l, e_busy);     chk("busy_msb", busy_m, e_busy);
      chk("ovf_lsb", ovf_l, m_ovf);        chk("ovf_msb", ovf_m, m_ovf);
    end

    if (!rst) begin
      m_valid = 1'b1; m_rf_pend = 1'b0; m_alu_pend = 1'b0; m_ovf = 1'b0;
      m_rf_buf = 8'h00; m_alu_buf = 16'h0000; m_last_alu = 1'b1; m_src_alu = 1'b0;
      q_l.delete(); q_m.delete();
    end else begin
      pop       = e_inc;
      last_byte = pop && (q_l.size() == 1);
      free_rf   = last_byte && !m_src_alu;
      free_alu  = last_byte && m_src_alu;
      was_idle  = !e_busy;
      if (pop) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
      if (was_idle) begin
        g_rf  = m_rf_pend && (!m_alu_pend || m_last_alu);
        g_alu = m_alu_pend && !g_rf;
        if (m_rf_pend && m_alu_pend) m_last_alu = g_alu;
        if (g_rf) begin
          q_l.push_back(m_rf_buf); q_m.push_back(m_rf_buf); m_src_alu = 1'b0;
        end else if (g_alu) begin
          q_l.push_back(m_alu_buf[7:0]);  q_l.push_back(m_alu_buf[15:8]);
          q_m.push_back(m_alu_buf[15:8]); q_m.push_back(m_alu_buf[7:0]);
          m_src_alu = 1'b1;
        end
      end
      ovf_new = 1'b0;
      if (rv) begin
        if (m_rf_pend && !free_rf) ovf_new = 1'b1;
        else begin m_rf_buf = rd; m_rf_pend = 1'b1; end
      end else if (free_rf) m_rf_pend = 1'b0;
      if (ov) begin
        if (m_alu_pend && !free_alu) ovf_new = 1'b1;
        else begin m_alu_buf = alu; m_alu_pend = 1'b1; end
      end else if (free_alu) m_alu_pend = 1'b0;
      if (ovf_new) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
  endtask

  task automatic idle(input int n, input logic full);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, full, 1'b0);
  endtask

  initial begin
    // reset
    step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("rst_inc", obs_inc_l, 1'b0);  chk("rst_data", obs_dat_l, 8'h00);
    chk("rst_flags", {obs_rfp, obs_alp, obs_busy, obs_ovf}, 4'b0000);

    // single RF byte
    step(1'b1, 1'b1, 8'hA5, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("rf_t1_inc", obs_inc_l, 1'b0);
    idle(1, 1'b0);
    chk("rf_t2_inc", obs_inc_l, 1'b1); chk("rf_t2_data", obs_dat_l, 8'hA5);
    idle(1, 1'b0);
    chk("rf_t3_inc", obs_inc_l, 1'b0); chk("rf_t3_pend", obs_rfp, 1'b0);
    idle(2, 1'b0);

    // ALU byte order
    step(1'b1, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("alu_b0_inc", obs_inc_l, 1'b1);
    chk("alu_b0_lsb", obs_dat_l, 8'h34); chk("alu_b0_msb", obs_dat_m, 8'h12);
    idle(1, 1'b0);
    chk("alu_b1_inc", obs_inc_m, 1'b1);
    chk("alu_b1_lsb", obs_dat_l, 8'h12); chk("alu_b1_msb", obs_dat_m, 8'h34);
    idle(2, 1'b0);

    // simultaneous strobes: RF wins the first tie, ALU the next
    step(1'b1, 1'b1, 8'h5A, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("tie1_rf", obs_dat_l, 8'h5A);
    idle(2, 1'b0);
    chk("tie1_alu", obs_dat_l, 8'hEF);
    idle(3, 1'b0);
    step(1'b1, 1'b1, 8'hC3, 1'b1, 16'h1357, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("tie2_alu_b0", obs_dat_l, 8'h57);
    idle(1, 1'b0);
    chk("tie2_alu_b1", obs_dat_l, 8'h13);
    idle(2, 1'b0);
    chk("tie2_rf", obs_dat_l, 8'hC3); chk("tie2_rf_inc", obs_inc_l, 1'b1);
    idle(2, 1'b0);

    // FIFO full during second ALU byte
    step(1'b1, 1'b0, 8'h00, 1'b1, 16'hCAFE, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("full_b0", obs_dat_l, 8'hFE);
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b1);
      chk("full_hold_inc", obs_inc_l, 1'b0); chk("full_hold_data", obs_dat_l, 8'hCA);
    end
    idle(1, 1'b0);
    chk("full_rel_inc", obs_inc_l, 1'b1); chk("full_rel_data", obs_dat_l, 8'hCA);
    idle(2, 1'b0);

    // overflow while blocked, then clear
    cnt77 = 0;
    step(1'b1, 1'b1, 8'hA1, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle(1, 1'b1);
    step(1'b1, 1'b1, 8'h77, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("ovf_set", obs_ovf, 1'b1);
    idle(2, 1'b1);
    idle(1, 1'b0);
    chk("ovf_orig_inc", obs_inc_l, 1'b1); chk("ovf_orig_data", obs_dat_l, 8'hA1);
    idle(3, 1'b0);
    chk("ovf_no77", cnt77, 16'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("ovf_clr", obs_ovf, 1'b0);

    // refill on the freeing cycle
    step(1'b1, 1'b1, 8'h11, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 1'b1, 8'h22, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("refill_first", obs_dat_l, 8'h11);
    idle(1, 1'b0);
    chk("refill_pend", obs_rfp, 1'b1); chk("refill_ovf", obs_ovf, 1'b0);
    idle(1, 1'b0);
    chk("refill_second", obs_dat_l, 8'h22);
    idle(2, 1'b0);

    // reset during SEND_ALU_B1
    step(1'b1, 1'b0, 8'h00, 1'b1, 16'h5678, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("midrst_inc", obs_inc_l, 1'b0);
    idle(1, 1'b0);
    chk("midrst_flags", {obs_rfp, obs_alp, obs_busy, obs_ovf}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0);
      chk("midrst_no_wr", obs_inc_l, 1'b0);
    end

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) != 0), ($urandom_range(99) < 30), 8'($urandom),
           ($urandom_range(99) < 20), 16'($urandom),
           ($urandom_range(99) < 25), ($urandom_range(99) < 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
